// File: rtl/fifo_arb_pkg.sv
// Shared types and default parameters for the FIFO write-side arbiter.
package fifo_arb_pkg;

  typedef enum logic {IDLE, BURST} arb_state_t;

  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_DATA_W    = 8;
  localparam int DEF_MAX_BURST = 8;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above start, wrapping.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] start,
  output logic                       found,
  output logic [$clog2(NUM_REQ)-1:0] idx
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] cand;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'((int'(start) + k) % NUM_REQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locked arbiter sharing the FIFO write port between producers.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ-1:0]          req_last,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic                        fifo_full,
  output logic                        fifo_wr,
  output logic [DATA_W-1:0]           fifo_data,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        busy,
  output logic                        trunc
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  arb_state_t       state, state_nxt;
  logic [IDX_W-1:0] rr_ptr;
  logic [CNT_W-1:0] beat_cnt;
  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic             xfer;
  logic             burst_end;
  logic             g_last;
  logic [DATA_W-1:0] data_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
    assign data_arr[i] = req_data[i*DATA_W +: DATA_W];
  end

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req   (req_valid),
    .start (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign busy = (state == BURST);

  // Reset gates the handshake so a byte presented during reset is never written.
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    fifo_wr   = 1'b0;
    fifo_data = '0;
    xfer      = 1'b0;
    burst_end = 1'b0;
    g_last    = req_last[grant_id];
    case (state)
      IDLE: begin
        if (pick_found) state_nxt = BURST;
      end
      BURST: begin
        req_ready[grant_id] = !fifo_full && !reset;
        xfer = req_valid[grant_id] && !fifo_full && !reset;
        if (xfer) begin
          fifo_wr   = 1'b1;
          fifo_data = data_arr[grant_id];
          burst_end = g_last || (beat_cnt == CNT_W'(MAX_BURST - 1));
          if (burst_end) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant_id <= '0;
      beat_cnt <= '0;
      trunc    <= 1'b0;
    end else begin
      state <= state_nxt;
      trunc <= burst_end && !g_last;
      if (state == IDLE && pick_found) begin
        grant_id <= pick_idx;
        beat_cnt <= '0;
      end else if (xfer) begin
        beat_cnt <= beat_cnt + CNT_W'(1);
      end
      if (burst_end) begin
        rr_ptr <= (grant_id == IDX_W'(NUM_REQ - 1)) ? '0 : grant_id + IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: vector table plus multi-cycle sequences.
module tb_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [3:0]  req_last;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        fifo_full;
  logic        fifo_wr;
  logic [7:0]  fifo_data;
  logic [1:0]  grant_id;
  logic        busy;
  logic        trunc;

  logic full_drv  = 1'b0;
  logic use_model = 1'b0;
  logic model_clr = 1'b1;
  logic fifo_rd   = 1'b0;
  int   fifo_count = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  assign fifo_full = use_model ? (fifo_count == 32) : full_drv;

  // Reference 32-entry FIFO occupancy.
  always @(posedge clk) begin
    if (model_clr) fifo_count <= 0;
    else fifo_count <= fifo_count + (fifo_wr ? 1 : 0) - ((fifo_rd && fifo_count > 0) ? 1 : 0);
  end

  fifo_wr_arbiter #(.NUM_REQ(4), .DATA_W(8), .MAX_BURST(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_data  (req_data),
    .req_ready (req_ready),
    .fifo_full (fifo_full),
    .fifo_wr   (fifo_wr),
    .fifo_data (fifo_data),
    .grant_id  (grant_id),
    .busy      (busy),
    .trunc     (trunc)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  valid;
    logic [3:0]  last;
    logic [31:0] data;
    logic        full;
    logic [3:0]  e_ready;
    logic        e_wr;
    logic [7:0]  e_data;
    logic [1:0]  e_gid;
    logic        e_busy;
    logic        e_trunc;
  } vec_t;

  vec_t vecs[23];

  function automatic vec_t mk(logic rst, logic [3:0] valid, logic [3:0] last, logic [31:0] data,
                              logic full, logic [3:0] e_ready, logic e_wr, logic [7:0] e_data,
                              logic [1:0] e_gid, logic e_busy, logic e_trunc);
    vec_t v;
    v.rst = rst; v.valid = valid; v.last = last; v.data = data; v.full = full;
    v.e_ready = e_ready; v.e_wr = e_wr; v.e_data = e_data; v.e_gid = e_gid;
    v.e_busy = e_busy; v.e_trunc = e_trunc;
    return v;
  endfunction

  task automatic applyStimulus(input logic rst, input logic [3:0] valid, input logic [3:0] last,
                               input logic [31:0] data, input logic full);
    reset     = rst;
    req_valid = valid;
    req_last  = last;
    req_data  = data;
    full_drv  = full;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic resetDut();
    applyStimulus(1'b1, 4'h0, 4'h0, 32'h0, 1'b0);
    tick();
    tick();
    applyStimulus(1'b0, 4'h0, 4'h0, 32'h0, 1'b0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int sent, writes, truncs, stall_cycles, rd_cycle, aa_cycle;
    logic [7:0] exp_byte;

    // Reset/idle, single burst, round-robin order, full stall, valid drop mid-burst.
    vecs[0]  = mk(1, 4'h0, 4'h0, 32'h0,        0, 4'h0, 0, 8'h00, 2'd0, 0, 0);
    vecs[1]  = mk(0, 4'h0, 4'h0, 32'h0,        0, 4'h0, 0, 8'h00, 2'd0, 0, 0);
    vecs[2]  = mk(0, 4'h4, 4'h0, 32'h00110000, 0, 4'h0, 0, 8'h00, 2'd0, 0, 0);
    vecs[3]  = mk(0, 4'h4, 4'h0, 32'h00110000, 0, 4'h4, 1, 8'h11, 2'd2, 1, 0);
    vecs[4]  = mk(0, 4'h4, 4'h0, 32'h00220000, 0, 4'h4, 1, 8'h22, 2'd2, 1, 0);
    vecs[5]  = mk(0, 4'h4, 4'h4, 32'h00330000, 0, 4'h4, 1, 8'h33, 2'd2, 1, 0);
    vecs[6]  = mk(0, 4'h0, 4'h0, 32'h0,        0, 4'h0, 0, 8'h00, 2'd2, 0, 0);
    vecs[7]  = mk(0, 4'hF, 4'hF, 32'hA3A2A1A0, 0, 4'h0, 0, 8'h00, 2'd2, 0, 0);
    vecs[8]  = mk(0, 4'hF, 4'hF, 32'hA3A2A1A0, 0, 4'h8, 1, 8'hA3, 2'd3, 1, 0);
    vecs[9]  = mk(0, 4'hF, 4'hF, 32'hA3A2A1A0, 0, 4'h0, 0, 8'h00, 2'd3, 0, 0);
    vecs[10] = mk(0, 4'hF, 4'hF, 32'hA3A2A1A0, 0, 4'h1, 1, 8'hA0, 2'd0, 1, 0);
    vecs[11] = mk(0, 4'hF, 4'hF, 32'hA3A2A1A0, 0, 4'h0, 0, 8'h00, 2'd0, 0, 0);
    vecs[12] = mk(0, 4'hF, 4'hF, 32'hA3A2A1A0, 0, 4'h2, 1, 8'hA1, 2'd1, 1, 0);
    vecs[13] = mk(0, 4'hF, 4'hF, 32'hA3A2A1A0, 0, 4'h0, 0, 8'h00, 2'd1, 0, 0);
    vecs[14] = mk(0, 4'hF, 4'hF, 32'hA3A2A1A0, 0, 4'h4, 1, 8'hA2, 2'd2, 1, 0);
    vecs[15] = mk(0, 4'h0, 4'h0, 32'h0,        0, 4'h0, 0, 8'h00, 2'd2, 0, 0);
    vecs[16] = mk(0, 4'h1, 4'h0, 32'h000000A0, 1, 4'h0, 0, 8'h00, 2'd2, 0, 0);
    vecs[17] = mk(0, 4'h1, 4'h0, 32'h000000A0, 1, 4'h0, 0, 8'h00, 2'd0, 1, 0);
    vecs[18] = mk(0, 4'h1, 4'h1, 32'h00000055, 0, 4'h1, 1, 8'h55, 2'd0, 1, 0);
    vecs[19] = mk(0, 4'h2, 4'h0, 32'h00000100, 0, 4'h0, 0, 8'h00, 2'd0, 0, 0);
    vecs[20] = mk(0, 4'h0, 4'h0, 32'h0,        0, 4'h2, 0, 8'h00, 2'd1, 1, 0);
    vecs[21] = mk(0, 4'h2, 4'h2, 32'h00000200, 0, 4'h2, 1, 8'h02, 2'd1, 1, 0);
    vecs[22] = mk(0, 4'h0, 4'h0, 32'h0,        0, 4'h0, 0, 8'h00, 2'd1, 0, 0);

    applyStimulus(1'b1, 4'h0, 4'h0, 32'h0, 1'b0);
    #1;
    tick();
    tick();
    model_clr = 1'b0;

    for (int i = 0; i < 23; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].valid, vecs[i].last, vecs[i].data, vecs[i].full);
      #2;
      checkOutput($sformatf("v%0d_ready", i), 32'(req_ready), 32'(vecs[i].e_ready));
      checkOutput($sformatf("v%0d_wr", i),    32'(fifo_wr),   32'(vecs[i].e_wr));
      checkOutput($sformatf("v%0d_data", i),  32'(fifo_data), 32'(vecs[i].e_data));
      checkOutput($sformatf("v%0d_gid", i),   32'(grant_id),  32'(vecs[i].e_gid));
      checkOutput($sformatf("v%0d_busy", i),  32'(busy),      32'(vecs[i].e_busy));
      checkOutput($sformatf("v%0d_trunc", i), 32'(trunc),     32'(vecs[i].e_trunc));
      tick();
    end

    // Producer 1 streams 12 bytes with no last; MAX_BURST splits it 8 + 4.
    resetDut();
    sent = 0; writes = 0; truncs = 0;
    for (int cyc = 0; cyc < 80 && writes < 12; cyc++) begin
      applyStimulus(1'b0, (sent < 12) ? 4'h2 : 4'h0, 4'h0, {16'h0, 8'(sent), 8'h0}, 1'b0);
      #2;
      if (trunc) begin
        truncs++;
        checkOutput("trunc_after_8", 32'(writes), 32'd8);
      end
      if (fifo_wr) begin
        checkOutput("trunc_data", 32'(fifo_data), 32'(sent));
        checkOutput("trunc_gid", 32'(grant_id), 32'd1);
        writes++;
      end
      if (req_ready[1] && req_valid[1]) sent++;
      tick();
    end
    checkOutput("trunc_writes", 32'(writes), 32'd12);
    checkOutput("trunc_pulses", 32'(truncs), 32'd1);

    // Fill the FIFO model to 32, then 0xAA must wait for one read.
    resetDut();
    model_clr = 1'b1;
    tick();
    model_clr = 1'b0;
    use_model = 1'b1;
    sent = 0; writes = 0; stall_cycles = 0; rd_cycle = -1; aa_cycle = -1;
    for (int cyc = 0; cyc < 300 && sent < 33; cyc++) begin
      exp_byte = (sent < 32) ? 8'(sent) : 8'hAA;
      applyStimulus(1'b0, 4'h1, 4'h0, {24'h0, exp_byte}, 1'b0);
      fifo_rd = (stall_cycles == 3 && rd_cycle < 0);
      if (fifo_rd) rd_cycle = cyc;
      #2;
      if (fifo_full) begin
        checkOutput("stall_ready", 32'(req_ready), 32'd0);
        checkOutput("stall_wr", 32'(fifo_wr), 32'd0);
        stall_cycles++;
      end
      if (fifo_wr) begin
        checkOutput("stall_data", 32'(fifo_data), 32'(exp_byte));
        writes++;
        if (sent == 32) aa_cycle = cyc;
      end
      if (req_ready[0]) sent++;
      tick();
      fifo_rd = 1'b0;
    end
    checkOutput("stall_writes", 32'(writes), 32'd33);
    checkOutput("stall_aa_timing", 32'(aa_cycle), 32'(rd_cycle + 1));
    checkOutput("stall_count", 32'(fifo_count), 32'd32);
    use_model = 1'b0;

    // Reset during a burst after two bytes: no more writes and rr_ptr back to 0.
    resetDut();
    applyStimulus(1'b0, 4'h4, 4'h4, 32'h00EE0000, 1'b0);
    tick();
    #2;
    checkOutput("mrst_pre_data", 32'(fifo_data), 32'hEE);
    tick();
    applyStimulus(1'b0, 4'h2, 4'h0, 32'h0000C000, 1'b0);
    tick();
    #2;
    checkOutput("mrst_b0", {fifo_wr, fifo_data}, {1'b1, 8'hC0});
    tick();
    applyStimulus(1'b0, 4'h2, 4'h0, 32'h0000C100, 1'b0);
    #2;
    checkOutput("mrst_b1", {fifo_wr, fifo_data}, {1'b1, 8'hC1});
    tick();
    applyStimulus(1'b1, 4'h2, 4'h0, 32'h0000C200, 1'b0);
    #2;
    checkOutput("mrst_no_wr", {fifo_wr, req_ready}, 5'h0);
    tick();
    applyStimulus(1'b0, 4'h0, 4'h0, 32'h0, 1'b0);
    #2;
    checkOutput("mrst_state", {busy, trunc, fifo_wr, grant_id}, 5'h0);
    tick();
    applyStimulus(1'b0, 4'hF, 4'hF, 32'hA3A2A1A0, 1'b0);
    tick();
    #2;
    checkOutput("mrst_rr_ptr", {fifo_wr, grant_id, fifo_data}, {1'b1, 2'd0, 8'hA0});
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
